// File: rtl/control_calculadora.sv
// Keypad calculator sequencer: two decimal operands, +/-, double-dabble BCD conversion.
// Optional macro CALC_BORRAR_EN enables '#' as backspace while entering an operand.
module control_calculadora #(
    parameter int MAX_DIGITOS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  tecla,
    input  logic        tecla_valida,
    output logic [15:0] display_bcd,
    output logic        signo,
    output logic        ocupado,
    output logic [1:0]  estado,
    output logic        tecla_perdida
);

    typedef enum logic [1:0] {
        OP_A      = 2'b00,
        OP_B      = 2'b01,
        CONV      = 2'b10,
        RESULTADO = 2'b11
    } estado_t;

    typedef enum logic {
        SUMA,
        RESTA
    } operador_t;

    typedef struct packed {
        logic [9:0]  bin;
        logic [11:0] bcd;
        logic [1:0]  cnt;
    } operando_t;

    localparam operando_t  OPERANDO_CERO = '0;
    localparam logic [1:0] MAX_CNT       = 2'(MAX_DIGITOS);
    localparam logic [3:0] K_MAS         = 4'hA;
    localparam logic [3:0] K_MENOS       = 4'hB;
    localparam logic [3:0] K_BORRA       = 4'hC;
    localparam logic [3:0] K_IGUAL       = 4'hD;
    localparam logic [3:0] K_TODO        = 4'hE;
`ifdef CALC_BORRAR_EN
    localparam logic [3:0] K_ATRAS       = 4'hF;
`endif
    localparam logic [3:0] ULTIMA_ITER   = 4'd11;

    estado_t    state;
    operador_t  op;
    operando_t  a, b;
    logic [10:0] res_mag;
    logic [26:0] dd;
    logic [3:0]  iter;

    function automatic operando_t meter_digito(operando_t o, logic [3:0] d);
        operando_t r;
        r = o;
        if (o.cnt < MAX_CNT) begin
            r.bin = o.bin * 10'd10 + {6'd0, d};
            r.bcd = {o.bcd[7:0], d};
            r.cnt = o.cnt + 2'd1;
        end
        return r;
    endfunction

`ifdef CALC_BORRAR_EN
    function automatic operando_t borrar_digito(operando_t o);
        operando_t r;
        r.bcd = {4'h0, o.bcd[11:4]};
        r.cnt = o.cnt - 2'd1;
        r.bin = {6'd0, r.bcd[11:8]} * 10'd100 + {6'd0, r.bcd[7:4]} * 10'd10 + {6'd0, r.bcd[3:0]};
        return r;
    endfunction
`endif

    // One double-dabble step: {bcd[15:0], bin[10:0]}, adjust nibbles >= 5 then shift left.
    function automatic logic [26:0] paso_dabble(logic [26:0] v);
        logic [26:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[11 + 4*i +: 4] >= 4'd5)
                r[11 + 4*i +: 4] = r[11 + 4*i +: 4] + 4'd3;
        end
        return {r[25:0], 1'b0};
    endfunction

    logic        es_digito, es_oper, clear_all;
    operando_t   a_dig, b_dig, primer_digito;
    operador_t   op_tecla;
    logic [10:0] mag;
    logic        negativo;
`ifdef CALC_BORRAR_EN
    operando_t   a_atras, b_atras;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        es_digito     = (tecla <= 4'd9);
        es_oper       = (tecla == K_MAS) || (tecla == K_MENOS);
        op_tecla      = (tecla == K_MENOS) ? RESTA : SUMA;
        a_dig         = meter_digito(a, tecla);
        b_dig         = meter_digito(b, tecla);
        primer_digito = meter_digito(OPERANDO_CERO, tecla);
`ifdef CALC_BORRAR_EN
        a_atras       = borrar_digito(a);
        b_atras       = borrar_digito(b);
`endif
        negativo      = (op == RESTA) && (a.bin < b.bin);
        mag           = {1'b0, a.bin} + {1'b0, b.bin};
        if (op == RESTA)
            mag = negativo ? ({1'b0, b.bin} - {1'b0, a.bin}) : ({1'b0, a.bin} - {1'b0, b.bin});

        clear_all = 1'b0;
        case (state)
            OP_A, OP_B: clear_all = tecla_valida && (tecla == K_TODO);
            RESULTADO:  clear_all = tecla_valida && ((tecla == K_BORRA) || (tecla == K_TODO));
            CONV:       clear_all = 1'b0;
            default:    clear_all = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        tecla_perdida <= 1'b0;
        if (rst || clear_all) begin
            state       <= OP_A;
            op          <= SUMA;
            a           <= OPERANDO_CERO;
            b           <= OPERANDO_CERO;
            res_mag     <= '0;
            dd          <= '0;
            iter        <= '0;
            display_bcd <= '0;
            signo       <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            case (state)
                OP_A: if (tecla_valida) begin
                    if (es_digito) begin
                        a           <= a_dig;
                        display_bcd <= {4'h0, a_dig.bcd};
                    end else if (es_oper) begin
                        op          <= op_tecla;
                        b           <= OPERANDO_CERO;
                        display_bcd <= '0;
                        state       <= OP_B;
                    end else if (tecla == K_BORRA) begin
                        a           <= OPERANDO_CERO;
                        display_bcd <= '0;
                    end
`ifdef CALC_BORRAR_EN
                    else if (tecla == K_ATRAS && a.cnt != 2'd0) begin
                        a           <= a_atras;
                        display_bcd <= {4'h0, a_atras.bcd};
                    end
`endif
                end
                OP_B: if (tecla_valida) begin
                    if (es_digito) begin
                        b           <= b_dig;
                        display_bcd <= {4'h0, b_dig.bcd};
                    end else if (es_oper) begin
                        if (b.cnt == 2'd0)
                            op <= op_tecla;
                    end else if (tecla == K_BORRA) begin
                        b           <= OPERANDO_CERO;
                        display_bcd <= '0;
                    end else if (tecla == K_IGUAL) begin
                        res_mag <= mag;
                        signo   <= negativo;
                        dd      <= {16'h0, mag};
                        iter    <= '0;
                        ocupado <= 1'b1;
                        state   <= CONV;
                    end
`ifdef CALC_BORRAR_EN
                    else if (tecla == K_ATRAS && b.cnt != 2'd0) begin
                        b           <= b_atras;
                        display_bcd <= {4'h0, b_atras.bcd};
                    end
`endif
                end
                CONV: begin
                    if (tecla_valida)
                        tecla_perdida <= 1'b1;
                    if (iter == ULTIMA_ITER) begin
                        display_bcd <= dd[26:11];
                        ocupado     <= 1'b0;
                        state       <= RESULTADO;
                    end else begin
                        dd   <= paso_dabble(dd);
                        iter <= iter + 4'd1;
                    end
                end
                RESULTADO: if (tecla_valida) begin
                    if (es_digito) begin
                        a           <= primer_digito;
                        b           <= OPERANDO_CERO;
                        op          <= SUMA;
                        res_mag     <= '0;
                        signo       <= 1'b0;
                        display_bcd <= {12'h0, tecla};
                        state       <= OP_A;
                    end else if (es_oper && !signo && res_mag <= 11'd999) begin
                        // The display still holds the result BCD here, so it seeds operand A.
                        a           <= '{bin: res_mag[9:0], bcd: display_bcd[11:0], cnt: MAX_CNT};
                        b           <= OPERANDO_CERO;
                        op          <= op_tecla;
                        display_bcd <= '0;
                        state       <= OP_B;
                    end
                end
                default: state <= OP_A;
            endcase
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_control_calculadora.sv
// Directed bench for control_calculadora: entry, +/-, chaining, conversion timing, lost keys, reset.
module tb_control_calculadora;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tecla;
    logic        tecla_valida;
    logic [15:0] display_bcd;
    logic        signo;
    logic        ocupado;
    logic [1:0]  estado;
    logic        tecla_perdida;

    int total = 0;
    int bad   = 0;

    control_calculadora #(.MAX_DIGITOS(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .tecla         (tecla),
        .tecla_valida  (tecla_valida),
        .display_bcd   (display_bcd),
        .signo         (signo),
        .ocupado       (ocupado),
        .estado        (estado),
        .tecla_perdida (tecla_perdida)
    );

    always #5 clk = ~clk;

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        tecla        = k;
        tecla_valida = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0;
    endtask

    // Counts edges until ocupado falls; bounded so a stuck conversion cannot hang the run.
    task automatic wait_conv(output int cyc);
        cyc = 0;
        while (ocupado === 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (display_bcd !== 16'h0000) begin bad++; $display("FAIL reset_display got=%h want=%h", display_bcd, 16'h0000); end
        total++; if (signo !== 1'b0) begin bad++; $display("FAIL reset_signo got=%b want=0", signo); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado got=%b want=0", ocupado); end
        total++; if (estado !== 2'b00) begin bad++; $display("FAIL reset_estado got=%b want=00", estado); end
        total++; if (tecla_perdida !== 1'b0) begin bad++; $display("FAIL reset_perdida got=%b want=0", tecla_perdida); end
    endtask

    task automatic test_digitos;
        press(4'd1); press(4'd2); press(4'd3);
        total++; if (display_bcd !== 16'h0123) begin bad++; $display("FAIL dig_three got=%h want=%h", display_bcd, 16'h0123); end
        press(4'd4);
        total++; if (display_bcd !== 16'h0123) begin bad++; $display("FAIL dig_fourth_ignored got=%h want=%h", display_bcd, 16'h0123); end
        total++; if (estado !== 2'b00) begin bad++; $display("FAIL dig_estado got=%b want=00", estado); end
        press(4'hC);
        total++; if (display_bcd !== 16'h0000) begin bad++; $display("FAIL dig_clear_entry got=%h want=%h", display_bcd, 16'h0000); end
    endtask

    task automatic test_suma;
        int cyc;
        press(4'd1); press(4'd2); press(4'hA);
        total++; if (estado !== 2'b01) begin bad++; $display("FAIL suma_to_opb got=%b want=01", estado); end
        total++; if (display_bcd !== 16'h0000) begin bad++; $display("FAIL suma_b_empty got=%h want=%h", display_bcd, 16'h0000); end
        press(4'd3); press(4'd4);
        total++; if (display_bcd !== 16'h0034) begin bad++; $display("FAIL suma_b_value got=%h want=%h", display_bcd, 16'h0034); end
        press(4'hD);
        total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL suma_busy_rise got=%b want=1", ocupado); end
        total++; if (estado !== 2'b10) begin bad++; $display("FAIL suma_conv_state got=%b want=10", estado); end
        total++; if (display_bcd !== 16'h0034) begin bad++; $display("FAIL suma_display_hold got=%h want=%h", display_bcd, 16'h0034); end
        wait_conv(cyc);
        total++; if (cyc !== 12) begin bad++; $display("FAIL suma_busy_edges got=%0d want=12", cyc); end
        total++; if (display_bcd !== 16'h0046) begin bad++; $display("FAIL suma_result got=%h want=%h", display_bcd, 16'h0046); end
        total++; if (signo !== 1'b0) begin bad++; $display("FAIL suma_signo got=%b want=0", signo); end
        total++; if (estado !== 2'b11) begin bad++; $display("FAIL suma_estado got=%b want=11", estado); end
        // Chain: 46 + 4 = 50
        press(4'hA);
        total++; if (estado !== 2'b01) begin bad++; $display("FAIL chain_to_opb got=%b want=01", estado); end
        press(4'd4); press(4'hD);
        wait_conv(cyc);
        total++; if (display_bcd !== 16'h0050) begin bad++; $display("FAIL chain_result got=%h want=%h", display_bcd, 16'h0050); end
    endtask

    task automatic test_resta;
        int cyc;
        press(4'd5);
        total++; if (display_bcd !== 16'h0005) begin bad++; $display("FAIL resta_newdigit got=%h want=%h", display_bcd, 16'h0005); end
        total++; if (estado !== 2'b00) begin bad++; $display("FAIL resta_newdigit_estado got=%b want=00", estado); end
        press(4'hB); press(4'd1); press(4'd2); press(4'hD);
        wait_conv(cyc);
        total++; if (display_bcd !== 16'h0007) begin bad++; $display("FAIL resta_result got=%h want=%h", display_bcd, 16'h0007); end
        total++; if (signo !== 1'b1) begin bad++; $display("FAIL resta_signo got=%b want=1", signo); end
        press(4'hA);
        total++; if (estado !== 2'b11) begin bad++; $display("FAIL resta_chain_blocked got=%b want=11", estado); end
        total++; if (display_bcd !== 16'h0007) begin bad++; $display("FAIL resta_chain_display got=%h want=%h", display_bcd, 16'h0007); end
    endtask

    task automatic test_limite;
        int cyc;
        press(4'd9); press(4'd9); press(4'd9); press(4'hA);
        press(4'd9); press(4'd9); press(4'd9); press(4'hD);
        wait_conv(cyc);
        total++; if (display_bcd !== 16'h1998) begin bad++; $display("FAIL max_result got=%h want=%h", display_bcd, 16'h1998); end
        total++; if (signo !== 1'b0) begin bad++; $display("FAIL max_signo got=%b want=0", signo); end
        press(4'hA);
        total++; if (estado !== 2'b11) begin bad++; $display("FAIL max_chain_blocked got=%b want=11", estado); end
        press(4'd7);
        total++; if (display_bcd !== 16'h0007) begin bad++; $display("FAIL max_newdigit got=%h want=%h", display_bcd, 16'h0007); end
        total++; if (estado !== 2'b00) begin bad++; $display("FAIL max_newdigit_estado got=%b want=00", estado); end
    endtask

    task automatic test_operador;
        int cyc;
        press(4'hE);
        // B count is 0, so '-' replaces '+': 8 - 3
        press(4'd8); press(4'hA); press(4'hB); press(4'd3); press(4'hD);
        wait_conv(cyc);
        total++; if (display_bcd !== 16'h0005) begin bad++; $display("FAIL op_replace got=%h want=%h", display_bcd, 16'h0005); end
        total++; if (signo !== 1'b0) begin bad++; $display("FAIL op_replace_signo got=%b want=0", signo); end
        press(4'hE);
        // B already has a digit, so '+' is ignored: 2 - 5
        press(4'd2); press(4'hB); press(4'd5); press(4'hA);
        total++; if (estado !== 2'b01) begin bad++; $display("FAIL op_ignored_estado got=%b want=01", estado); end
        press(4'hD);
        wait_conv(cyc);
        total++; if (display_bcd !== 16'h0003) begin bad++; $display("FAIL op_ignored_result got=%h want=%h", display_bcd, 16'h0003); end
        total++; if (signo !== 1'b1) begin bad++; $display("FAIL op_ignored_signo got=%b want=1", signo); end
    endtask

    task automatic test_back_to_back;
        press(4'hE);
        @(negedge clk);
        tecla = 4'd4; tecla_valida = 1'b1;
        @(negedge clk);
        tecla = 4'd5;
        @(negedge clk);
        tecla_valida = 1'b0;
        total++; if (display_bcd !== 16'h0045) begin bad++; $display("FAIL b2b_digits got=%h want=%h", display_bcd, 16'h0045); end
    endtask

    task automatic test_conv_perdida;
        int cyc;
        press(4'hC);
        press(4'd3); press(4'hA); press(4'd4); press(4'hD);
        @(negedge clk);
        tecla = 4'd2; tecla_valida = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0;
        total++; if (tecla_perdida !== 1'b1) begin bad++; $display("FAIL lost_pulse got=%b want=1", tecla_perdida); end
        @(negedge clk);
        total++; if (tecla_perdida !== 1'b0) begin bad++; $display("FAIL lost_pulse_width got=%b want=0", tecla_perdida); end
        wait_conv(cyc);
        total++; if (display_bcd !== 16'h0007) begin bad++; $display("FAIL lost_result got=%h want=%h", display_bcd, 16'h0007); end
        total++; if (estado !== 2'b11) begin bad++; $display("FAIL lost_estado got=%b want=11", estado); end
        // Reset in the middle of a 3 - 4 conversion, with a key on the same edge
        press(4'hE);
        press(4'd3); press(4'hB); press(4'd4); press(4'hD);
        total++; if (signo !== 1'b1) begin bad++; $display("FAIL rstconv_signo_before got=%b want=1", signo); end
        @(negedge clk);
        rst = 1'b1; tecla = 4'd5; tecla_valida = 1'b1;
        @(negedge clk);
        rst = 1'b0; tecla_valida = 1'b0;
        total++; if (display_bcd !== 16'h0000) begin bad++; $display("FAIL rstconv_display got=%h want=%h", display_bcd, 16'h0000); end
        total++; if (signo !== 1'b0) begin bad++; $display("FAIL rstconv_signo got=%b want=0", signo); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rstconv_ocupado got=%b want=0", ocupado); end
        total++; if (estado !== 2'b00) begin bad++; $display("FAIL rstconv_estado got=%b want=00", estado); end
        total++; if (tecla_perdida !== 1'b0) begin bad++; $display("FAIL rstconv_perdida got=%b want=0", tecla_perdida); end
        press(4'd6);
        total++; if (display_bcd !== 16'h0006) begin bad++; $display("FAIL rstconv_after got=%h want=%h", display_bcd, 16'h0006); end
    endtask

    task automatic test_borrar;
        int cyc;
        logic [15:0] exp_tras_f, exp_final;
`ifdef CALC_BORRAR_EN
        exp_tras_f = 16'h0012;
        exp_final  = 16'h0013;
`else
        exp_tras_f = 16'h0123;
        exp_final  = 16'h0124;
`endif
        press(4'hC);
        press(4'd1); press(4'd2); press(4'd3); press(4'hF);
        total++; if (display_bcd !== exp_tras_f) begin bad++; $display("FAIL bs_display got=%h want=%h", display_bcd, exp_tras_f); end
        press(4'hA); press(4'd1); press(4'hD);
        wait_conv(cyc);
        total++; if (display_bcd !== exp_final) begin bad++; $display("FAIL bs_result got=%h want=%h", display_bcd, exp_final); end
    endtask

    initial begin
        rst          = 1'b1;
        tecla        = 4'd0;
        tecla_valida = 1'b0;
        @(negedge clk);
        test_reset;
        test_digitos;
        test_suma;
        test_resta;
        test_limite;
        test_operador;
        test_back_to_back;
        test_conv_perdida;
        test_borrar;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_calculadora.md
Name: control_calculadora

Overview:
Sequencing controller for the keypad calculator. Consumes translated 4-bit key codes and the one-shot key-valid pulse from the keypad translator. Assembles two decimal operands and an operator, computes sum or difference, and converts the result to BCD with an iterative shift-add-3 (double-dabble) engine. Drives the 4-digit BCD display path plus sign and busy flags.

Parameters:
MAX_DIGITOS, 3, max digits accepted per operand; legal range 1..3; further digits are ignored.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
tecla  input  4  translated key code: 0-9 digits, A=+ (1010), B=- (1011), C=clear entry (1100), D== (1101), E=* clear all (1110), F=# (1111)
tecla_valida  input  1  one-cycle pulse; tecla sampled only when high
display_bcd  output  16  4 BCD digits, [15:12] most significant
signo  output  1  1 = displayed result is negative
ocupado  output  1  high while BCD conversion runs
estado  output  2  OP_A=00, OP_B=01, CONV=10, RESULTADO=11
tecla_perdida  output  1  one-cycle pulse when a valid key arrives during CONV

Behaviour:
- Reset (sync, rst=1 at edge): state OP_A; operands, counts, operator, result = 0; display_bcd=0x0000, signo=0, ocupado=0, tecla_perdida=0. Reset overrides any key in the same cycle, including mid-CONV.
- Operand storage: binary value (10 bits, max 999), BCD copy (12 bits), digit count (2 bits).
- Digit d entry: if count<MAX_DIGITOS: bin=bin*10+d, bcd={bcd[7:0],d}, count++. Otherwise no change. Leading zeros count as digits.
- Display: OP_A shows {4'h0,a_bcd}. OP_B shows {4'h0,b_bcd}. RESULTADO shows the result BCD. Display holds during CONV. All outputs are registered.
- OP_A:
  - digit: enter into A.
  - A/B: latch the operator; clear B and its count; go to OP_B.
  - C: A=0, count 0.
  - D and F: ignored.
  - E: full clear.
- OP_B:
  - digit: enter into B.
  - A/B: replaces the operator only if B count==0; otherwise ignored.
  - C: B=0, count 0.
  - E: full clear, back to OP_A.
  - D: compute res = A+B (signo=0), or for '-' res=|A-B| with signo=(A<B); enter CONV.
- CONV:
  - ocupado=1.
  - 11 iterations of double-dabble over the 11-bit magnitude (max 1998), one per cycle.
  - ocupado rises on the edge that samples D. On the 12th edge after that, display_bcd loads the result, ocupado=0, state goes to RESULTADO.
  - Any tecla_valida in CONV is discarded and pulses tecla_perdida next cycle.
- RESULTADO:
  - digit: full clear, then enter the digit into A, go to OP_A, signo=0.
  - A/B (chaining): if signo=0 and res<=999, A=res (count=MAX_DIGITOS, BCD=result), latch the operator, go to OP_B, signo=0. Otherwise ignored.
  - C/E: full clear.
  - D/F: ignored.
- Full clear: same values as reset.
- tecla_valida high for multiple consecutive cycles: each cycle is treated as a separate key. No internal debounce; the upstream one-shot guarantees single pulses.
- Unused state encodings recover to OP_A with full clear.

Optional Feature:
CALC_BORRAR_EN
- Defined: F (#) in OP_A/OP_B is backspace when count>0. bcd={4'h0,bcd[11:4]}, count--, bin recomputed from the BCD digits (d2*100+d1*10+d0) in the same edge. With count==0 it is ignored.
- Not defined: F is ignored in every state; no backspace logic is synthesized.

Test Plan:
1. Reset, keys 1,2,3,4 → display 0x0123, estado 00; the 4th digit is ignored. Then C → 0x0000.
2. Keys 1,2,A,3,4,D → ocupado=1 for exactly 12 edges, then display 0x0046, signo 0, estado 11.
3. Keys 5,B,1,2,D → display 0x0007, signo 1. Then A → ignored (signo=1), estado stays 11.
4. Keys 9,9,9,A,9,9,9,D → display 0x1998. Then A → ignored. Key 7 → display 0x0007, estado 00.
5. Keys 3,A,4,D, then tecla_valida with tecla=2 two cycles later → tecla_perdida 1-cycle pulse, result 0x0007 unaffected. Repeat with rst during CONV → all outputs 0, estado 00.
6. With CALC_BORRAR_EN: keys 1,2,3,F,A,1,D → display 0x0013. Without the macro: same keys → 0x0124.
